// File: rtl/pll_lock_rstgen_if.sv
// Signal bundle between the PLL lock reset sequencer and its consumers.
// master: the sequencer itself; slave: the logic driving lock/requests and reading resets.
interface pll_lock_rstgen_if;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       sys_rst_n;
  logic       dram_rst_n;
  logic       locked_ok;
  logic [1:0] state;
  logic [7:0] loss_count;

  modport master (
    input  pll_lock,
    input  soft_rst_req,
    output sys_rst_n,
    output dram_rst_n,
    output locked_ok,
    output state,
    output loss_count
  );

  modport slave (
    output pll_lock,
    output soft_rst_req,
    input  sys_rst_n,
    input  dram_rst_n,
    input  locked_ok,
    input  state,
    input  loss_count
  );
endinterface

// File: rtl/pll_lock_rstgen.sv
// Staged reset release behind a synchronized, stability-filtered PLL lock.
// Define PLL_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise loss_count reads 0.
module pll_lock_rstgen #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_lock_rstgen_if.master  bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABILIZE = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   loss_evt;
  logic                   sys_rst_n_q;
  logic                   dram_rst_n_q;
  logic                   locked_ok_q;

  // pll_lock is asynchronous to clk; only the last flop of the chain is trusted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = STABILIZE;
        end
      end
      STABILIZE: begin
        // lock dropping before release is just an unstable PLL, not a counted loss
        if (!lock_s || bus.soft_rst_req) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s || bus.soft_rst_req) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = !lock_s;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s || bus.soft_rst_req) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = !lock_s;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      sys_rst_n_q  <= 1'b0;
      dram_rst_n_q <= 1'b0;
      locked_ok_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_rst_n_q  <= (state_d == RELEASE) || (state_d == RUN);
      dram_rst_n_q <= (state_d == RUN);
      locked_ok_q  <= (state_d == RUN);
    end
  end

  assign bus.state      = state_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.dram_rst_n = dram_rst_n_q;
  assign bus.locked_ok  = locked_ok_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'h00;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_count = loss_q;
`else
  logic unused_loss_evt;

  assign unused_loss_evt = loss_evt;
  assign bus.loss_count  = 8'h00;
`endif

endmodule
